// File: rtl/bfloat16_subtractor.sv
// Multi-cycle bfloat16 subtract unit (diff = a - b) with start/ready/done handshake,
// round-to-nearest-even, subnormal support and IEEE-style special values.
module bfloat16_subtractor (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic [15:0] diff,
  output logic        invalid,
  output logic        overflow,
  output logic        inexact
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADDSUB,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [15:0] a_reg, b_reg;

  logic       a_sign, b_sign;
  logic [7:0] a_exp, b_exp;
  logic [6:0] a_frac, b_frac;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  logic        special;
  logic [15:0] special_result;
  logic        special_invalid;

  logic       sa_reg, sb_reg;
  logic [7:0] ea_reg, eb_reg, ma_reg, mb_reg;

  logic        a_ge;
  logic        x_sign;
  logic [7:0]  x_exp, y_exp, x_man, y_man, exp_diff;
  logic [3:0]  shift_amt;
  logic [10:0] y_raw, y_shift, y_lost, y_aligned;
  logic        sx_reg, eff_sub_reg;
  logic [8:0]  ex_reg;
  logic [10:0] mx_reg, my_reg;

  logic [11:0] sum_reg, sum_next;

  logic [3:0]  lzc;
  logic [8:0]  max_shift, norm_shift;
  logic [8:0]  en_reg, en_next;
  logic [10:0] mn_reg, mn_next;
  logic        zero_reg;

  logic        g_bit, r_bit, s_bit, lsb_bit, round_inc;
  logic [8:0]  mant_rnd;
  logic [8:0]  exp_rnd;
  logic [15:0] round_result;
  logic        round_overflow, round_inexact;

  logic [15:0] diff_reg;
  logic        invalid_reg, overflow_reg, inexact_reg;

  genvar gi;

  // Field extraction; b's sign is flipped so the rest of the unit is a plain adder.
  assign a_sign = a_reg[15];
  assign b_sign = ~b_reg[15];
  assign a_exp  = a_reg[14:7];
  assign b_exp  = b_reg[14:7];
  assign a_frac = a_reg[6:0];
  assign b_frac = b_reg[6:0];
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != 7'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != 7'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == 7'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == 7'd0);
  assign a_zero = (a_reg[14:0] == 15'd0);
  assign b_zero = (b_reg[14:0] == 15'd0);

  always_comb begin
    special         = 1'b1;
    special_result  = 16'h0000;
    special_invalid = 1'b0;
    if (a_nan || b_nan) begin
      special_result = 16'h7FC0;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      special_result  = 16'h7FC0;
      special_invalid = 1'b1;
    end else if (a_inf) begin
      special_result = a_reg;
    end else if (b_inf) begin
      special_result = {b_sign, b_reg[14:0]};
    end else if (a_zero && b_zero) begin
      special_result = {a_sign & b_sign, 15'd0};
    end else if (a_zero) begin
      special_result = {b_sign, b_reg[14:0]};
    end else if (b_zero) begin
      special_result = a_reg;
    end else begin
      special = 1'b0;
    end
  end

  // Alignment: X is the larger magnitude; Y is shifted right with a sticky LSB.
  assign a_ge     = {ea_reg, ma_reg} >= {eb_reg, mb_reg};
  assign x_sign   = a_ge ? sa_reg : sb_reg;
  assign x_exp    = a_ge ? ea_reg : eb_reg;
  assign y_exp    = a_ge ? eb_reg : ea_reg;
  assign x_man    = a_ge ? ma_reg : mb_reg;
  assign y_man    = a_ge ? mb_reg : ma_reg;
  assign exp_diff = x_exp - y_exp;
  assign shift_amt = (exp_diff > 8'd10) ? 4'd10 : exp_diff[3:0];
  assign y_raw    = {y_man, 3'b000};
  assign y_shift  = y_raw >> shift_amt;

  generate
    for (gi = 0; gi < 11; gi++) begin : g_sticky
      assign y_lost[gi] = y_raw[gi] & (shift_amt > 4'(gi));
    end
  endgenerate

  assign y_aligned = {y_shift[10:1], y_shift[0] | (|y_lost)};

  always_comb begin
    if (eff_sub_reg) begin
      sum_next = {1'b0, mx_reg} - {1'b0, my_reg};
    end else begin
      sum_next = {1'b0, mx_reg} + {1'b0, my_reg};
    end
  end

  // Normalisation: left shift is capped so the exponent never drops below 1.
  always_comb begin
    lzc = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (sum_reg[i]) lzc = 4'(10 - i);
    end
    max_shift  = ex_reg - 9'd1;
    norm_shift = ({5'd0, lzc} < max_shift) ? {5'd0, lzc} : max_shift;
    if (sum_reg[11]) begin
      mn_next = {sum_reg[11:2], sum_reg[1] | sum_reg[0]};
      en_next = ex_reg + 9'd1;
    end else begin
      mn_next = sum_reg[10:0] << norm_shift;
      en_next = ex_reg - norm_shift;
    end
  end

  assign lsb_bit   = mn_reg[3];
  assign g_bit     = mn_reg[2];
  assign r_bit     = mn_reg[1];
  assign s_bit     = mn_reg[0];
  assign round_inc = g_bit & (r_bit | s_bit | lsb_bit);
  assign mant_rnd  = {1'b0, mn_reg[10:3]} + {8'd0, round_inc};
  // A subnormal rounding up into the hidden bit becomes the smallest normal.
  assign exp_rnd   = mn_reg[10] ? (en_reg + {8'd0, mant_rnd[8]}) : {8'd0, mant_rnd[7]};

  always_comb begin
    round_result   = {sx_reg, exp_rnd[7:0], mant_rnd[6:0]};
    round_overflow = 1'b0;
    round_inexact  = g_bit | r_bit | s_bit;
    if (zero_reg) begin
      round_result  = 16'h0000;
      round_inexact = 1'b0;
    end else if (exp_rnd >= 9'd255) begin
      round_result   = {sx_reg, 8'hFF, 7'd0};
      round_overflow = 1'b1;
      round_inexact  = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_next = S_UNPACK;
      end
      S_UNPACK: state_next = special ? S_DONE : S_ALIGN;
      S_ALIGN:  state_next = S_ADDSUB;
      S_ADDSUB: state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      diff_reg     <= 16'h0000;
      invalid_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      inexact_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_UNPACK && special) begin
        diff_reg     <= special_result;
        invalid_reg  <= special_invalid;
        overflow_reg <= 1'b0;
        inexact_reg  <= 1'b0;
      end else if (state_reg == S_ROUND) begin
        diff_reg     <= round_result;
        invalid_reg  <= 1'b0;
        overflow_reg <= round_overflow;
        inexact_reg  <= round_inexact;
      end
    end
  end

  // Datapath registers need no reset: each stage only consumes what the previous one wrote.
  always_ff @(posedge clock) begin
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          a_reg <= a;
          b_reg <= b;
        end
      end
      S_UNPACK: begin
        sa_reg <= a_sign;
        sb_reg <= b_sign;
        ea_reg <= (a_exp == 8'd0) ? 8'd1 : a_exp;
        eb_reg <= (b_exp == 8'd0) ? 8'd1 : b_exp;
        ma_reg <= {a_exp != 8'd0, a_frac};
        mb_reg <= {b_exp != 8'd0, b_frac};
      end
      S_ALIGN: begin
        sx_reg      <= x_sign;
        eff_sub_reg <= sa_reg ^ sb_reg;
        ex_reg      <= {1'b0, x_exp};
        mx_reg      <= {x_man, 3'b000};
        my_reg      <= y_aligned;
      end
      S_ADDSUB: sum_reg <= sum_next;
      S_NORM: begin
        en_reg   <= en_next;
        mn_reg   <= mn_next;
        zero_reg <= (sum_reg == 12'd0);
      end
      default: ;
    endcase
  end

  assign diff     = diff_reg;
  assign invalid  = invalid_reg;
  assign overflow = overflow_reg;
  assign inexact  = inexact_reg;

endmodule

// File: tb/tb_bfloat16_subtractor.sv
// Bench for bfloat16_subtractor: directed vector table, handshake sequences and
// random operands checked against an exact wide-integer reference of a - b.
`timescale 1ns/1ps
module tb_bfloat16_subtractor;

  localparam int W = 272;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        ready, done, invalid, overflow, inexact;
  logic [15:0] diff;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic [2:0]  flags;  // {invalid, overflow, inexact}
    int          lat;
  } vec_t;

  vec_t vecs [15];

  bfloat16_subtractor dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .diff     (diff),
    .invalid  (invalid),
    .overflow (overflow),
    .inexact  (inexact)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-133, are subtracted
  // exactly, then rounded to nearest-even into the bfloat16 grid.
  task automatic ref_sub(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic [2:0] flags, output int lat);
    logic         sx, sy, sr, up;
    logic [7:0]   ex, ey;
    logic [6:0]   fx, fy;
    logic [W-1:0] vx, vy, mag, q, rem, half, ones;
    int           p, sh, e;
    sx = x[15]; sy = ~y[15];
    ex = x[14:7]; ey = y[14:7];
    fx = x[6:0]; fy = y[6:0];
    r = 16'h0000; flags = 3'b000; lat = 1;
    if ((ex == 8'hFF && fx != 7'd0) || (ey == 8'hFF && fy != 7'd0)) begin
      r = 16'h7FC0;
    end else if (ex == 8'hFF && ey == 8'hFF && sx != sy) begin
      r = 16'h7FC0; flags = 3'b100;
    end else if (ex == 8'hFF) begin
      r = x;
    end else if (ey == 8'hFF) begin
      r = {sy, y[14:0]};
    end else if (x[14:0] == 15'd0 && y[14:0] == 15'd0) begin
      r = {sx & sy, 15'd0};
    end else if (x[14:0] == 15'd0) begin
      r = {sy, y[14:0]};
    end else if (y[14:0] == 15'd0) begin
      r = x;
    end else begin
      lat = 5;
      vx = '0; vx[7:0] = {ex != 8'd0, fx};
      if (ex != 8'd0) vx = vx << (int'(ex) - 1);
      vy = '0; vy[7:0] = {ey != 8'd0, fy};
      if (ey != 8'd0) vy = vy << (int'(ey) - 1);
      if (sx == sy) begin mag = vx + vy; sr = sx; end
      else if (vx >= vy) begin mag = vx - vy; sr = sx; end
      else begin mag = vy - vx; sr = sy; end
      if (mag != '0) begin
        p = 0;
        for (int i = 0; i < W; i++) if (mag[i]) p = i;
        if (p < 7) begin e = 0; sh = 0; end
        else begin e = p - 6; sh = p - 7; end
        ones = '1;
        q    = mag >> sh;
        rem  = mag & ~(ones << sh);
        half = '0;
        if (sh > 0) half[sh-1] = 1'b1;
        up = (rem > half) || (rem == half && rem != '0 && q[0]);
        if (up) q = q + 1;
        if (q[8]) begin q = q >> 1; e = e + 1; end
        if (e >= 255) begin
          r = {sr, 8'hFF, 7'd0}; flags = 3'b011;
        end else begin
          r = {sr, 8'(e), q[6:0]}; flags = {2'b00, rem != '0};
        end
      end
    end
  endtask

  // Issues one operation once ready, scrambles a/b after acceptance, and waits for done.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, output logic [15:0] r,
                        output logic [2:0] flags, output int lat, output int waited);
    waited = 0;
    @(negedge clock);
    while (!ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (done) begin lat = i; break; end
    end
    r = diff;
    flags = {invalid, overflow, inexact};
  endtask

  initial begin
    logic [15:0] r, er, x, y, held;
    logic [2:0]  fl, efl;
    int          lat, elat, waited, pulses, first_lat, mode;

    vecs[0]  = '{16'h4040, 16'h3F80, 16'h4000, 3'b000, 5};
    vecs[1]  = '{16'h3F80, 16'h3F80, 16'h0000, 3'b000, 5};
    vecs[2]  = '{16'h8000, 16'h0000, 16'h8000, 3'b000, 1};
    vecs[3]  = '{16'h0000, 16'h8000, 16'h0000, 3'b000, 1};
    vecs[4]  = '{16'h7F80, 16'h7F80, 16'h7FC0, 3'b100, 1};
    vecs[5]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 3'b000, 1};
    vecs[6]  = '{16'hFF80, 16'h7F80, 16'hFF80, 3'b000, 1};
    vecs[7]  = '{16'h3F80, 16'h3B00, 16'h3F80, 3'b001, 5};
    vecs[8]  = '{16'h7F7F, 16'hFF7F, 16'h7F80, 3'b011, 5};
    vecs[9]  = '{16'h0100, 16'h0080, 16'h0080, 3'b000, 5};
    vecs[10] = '{16'h0080, 16'h0001, 16'h007F, 3'b000, 5};
    vecs[11] = '{16'h0001, 16'h0002, 16'h8001, 3'b000, 5};
    vecs[12] = '{16'h0000, 16'h3F80, 16'hBF80, 3'b000, 1};
    vecs[13] = '{16'h3F80, 16'hBB80, 16'h3F80, 3'b001, 5};
    vecs[14] = '{16'h3F81, 16'hBB80, 16'h3F82, 3'b001, 5};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'h0000);
    check("reset_flags", 32'({invalid, overflow, inexact}), 32'd0);
    $display("[TB] reset: ready=%b done=%b diff=%h", ready, done, diff);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, r, fl, lat, waited);
      $display("[TB] vec %0d: %h - %h -> %h flags=%b lat=%0d", i, vecs[i].a, vecs[i].b, r, fl, lat);
      check($sformatf("vec%0d_diff", i), 32'(r), 32'(vecs[i].diff));
      check($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].flags));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // start issued in the cycle after done must be accepted immediately
    run_op(16'h4040, 16'h3F80, r, fl, lat, waited);
    run_op(16'h7F80, 16'h7F80, r, fl, lat, waited);
    $display("[TB] back-to-back: waited=%0d diff=%h lat=%0d", waited, r, lat);
    check("b2b_wait", 32'(waited), 32'd1);
    check("b2b_diff", 32'(r), 32'h7FC0);
    held = diff;
    repeat (5) @(posedge clock);
    #1;
    $display("[TB] hold: diff=%h invalid=%b after idle cycles", diff, invalid);
    check("hold_diff", 32'(diff), 32'(held));
    check("hold_invalid", 32'(invalid), 32'd1);

    // start pulses while busy are ignored
    @(negedge clock);
    a = 16'h4040; b = 16'h3F80; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    pulses = 0; first_lat = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 2 || i == 3) begin
        start = 1'b1; a = 16'h7F80; b = 16'h7F80;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      if (done) begin
        pulses++;
        if (first_lat < 0) first_lat = i;
      end
    end
    $display("[TB] busy-start: pulses=%0d lat=%0d diff=%h invalid=%b", pulses, first_lat, diff, invalid);
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_lat", 32'(first_lat), 32'd5);
    check("busy_diff", 32'(diff), 32'h4000);
    check("busy_invalid", 32'(invalid), 32'd0);

    // reset at E+3 aborts the operation
    @(negedge clock);
    a = 16'h3F80; b = 16'h3B00; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_diff", 32'(diff), 32'h0000);
    pulses = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    $display("[TB] reset mid-op: ready=%b diff=%h done_pulses=%0d", ready, diff, pulses);
    check("rst_mid_no_done", 32'(pulses), 32'd0);
    check("rst_mid_diff_hold", 32'(diff), 32'h0000);

    // reset and start together: reset wins
    @(negedge clock);
    a = 16'h4040; b = 16'h3F80; start = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; reset = 1'b0;
    check("rst_start_ready", 32'(ready), 32'd1);
    pulses = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    $display("[TB] reset+start: ready=%b done_pulses=%0d", ready, pulses);
    check("rst_start_no_done", 32'(pulses), 32'd0);

    for (int n = 0; n < 200; n++) begin
      mode = $urandom_range(0, 3);
      x = 16'($urandom);
      case (mode)
        0: y = 16'($urandom);
        1: y = {x[15], x[14:0] + 15'($urandom_range(0, 15))};
        2: begin
          x = {x[15], 6'd0, x[8:0]};
          y = {1'($urandom), 6'd0, 9'($urandom)};
        end
        default: begin
          x = {x[15], 2'b11, x[12:0]};
          y = {1'($urandom), 2'b11, 13'($urandom)};
        end
      endcase
      ref_sub(x, y, er, efl, elat);
      run_op(x, y, r, fl, lat, waited);
      $display("[TB] rnd %0d: %h - %h -> %h flags=%b lat=%0d (model %h %b %0d)",
               n, x, y, r, fl, lat, er, efl, elat);
      check($sformatf("rnd%0d_diff", n), 32'(r), 32'(er));
      check($sformatf("rnd%0d_flags", n), 32'(fl), 32'(efl));
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
